mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the pipelined core's fetch stage (IF) and memory stage (DM).
- Sequences each access through a small FSM: grant, hold the bus until the memory is ready, then return data with a one-cycle acknowledge.
- Generates byte enables and store-lane replication from the size/sign fields the decoder produces, and sign/zero-extends load data.
- Drives per-stage stall signals into the pipeline hazard logic.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- MAX_WAIT, 15, cycles a granted access may wait for MEM_READY before timeout (used only with the optional feature)

Ports:
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- IF_REQ  in  1  fetch request; held until IF_ACK
- IF_ADDR  in  ADDR_W  fetch address; word-aligned
- IF_RDATA  out  32  fetched instruction; valid when IF_ACK
- IF_ACK  out  1  one-cycle fetch completion pulse
- DM_REQ  in  1  data request; held until DM_ACK
- DM_WE  in  1  1 = store, 0 = load
- DM_SIZE  in  2  0 = byte, 1 = half, 2 = word
- DM_SIGN  in  1  1 = zero-extend load (unsigned), 0 = sign-extend
- DM_ADDR  in  ADDR_W  data byte address
- DM_WDATA  in  32  store data, right-aligned
- DM_RDATA  out  32  extended load data; valid when DM_ACK
- DM_ACK  out  1  one-cycle data completion pulse
- DM_ERR  out  1  pulse with DM_ACK on a misaligned or timed-out access
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  memory write enable
- MEM_BE  out  4  byte enables
- MEM_ADDR  out  ADDR_W  word address; bits [1:0] forced to 0
- MEM_WDATA  out  32  lane-replicated store data
- MEM_RDATA  in  32  raw memory word
- MEM_READY  in  1  memory completes the current access this cycle
- STALL_IF  out  1  IF_REQ && !IF_ACK
- STALL_DM  out  1  DM_REQ && !DM_ACK

Behaviour:
- Reset: FSM = IDLE. All registered outputs are 0: MEM_*, IF_ACK, DM_ACK, DM_ERR, IF_RDATA, DM_RDATA.
- FSM states:
  - IDLE
    - DM_REQ masked-valid → DM_BUSY.
    - Otherwise IF_REQ masked-valid → IF_BUSY.
    - Data has fixed priority over fetch because it belongs to the older instruction.
  - IF_BUSY / DM_BUSY
    - MEM_REQ = 1.
    - MEM_ADDR, MEM_WE, MEM_BE and MEM_WDATA are captured at grant and held stable until MEM_READY.
    - On MEM_READY: capture data, pulse that requester's ACK on the next cycle, return to IDLE.
- Masking: in IDLE, a requester whose ACK is high this cycle is ignored. This prevents a re-issue of a request that has just completed.
- Latency: request seen in IDLE at cycle t → MEM_REQ high from t+1 → MEM_READY at cycle t+k (k ≥ 1) → ACK at t+k+1. Minimum is 2 cycles.
- Back-to-back: with both requesters continuously requesting, grants alternate in the order DM, IF (masked), DM, ...
- Byte enables and lanes (o = DM_ADDR[1:0]):
  - byte: BE = 0001 << o; WDATA = byte replicated ×4.
  - half: BE = 0011 << o; WDATA = half replicated ×2.
  - word: BE = 1111.
  - Fetch: BE = 1111, WE = 0.
- Load extract: select the lane at o from MEM_RDATA, then zero-extend when DM_SIGN = 1, otherwise sign-extend.
- Misaligned access (half with o[0] = 1, word with o ≠ 0, or DM_SIZE = 3):
  - No MEM_REQ is issued.
  - DM_ACK and DM_ERR pulse on the next cycle; DM_RDATA = 0.
- Reset asserted mid-access: MEM_REQ drops immediately (asynchronous); no ACK is produced.
- STALL_IF / STALL_DM are combinational from the inputs and the registered ACKs.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A 4-bit-or-wider wait counter clears at grant and increments each BUSY cycle without MEM_READY.
  - On reaching MAX_WAIT: MEM_REQ drops and the FSM returns to IDLE.
  - A DM access gets ACK + DM_ERR with RDATA = 0.
  - An IF access gets IF_ACK with IF_RDATA = 32'h00000013 (NOP).
- When undefined: no counter exists and the FSM waits indefinitely.

Test Plan:
- IF_REQ at 0x100, MEM_READY on the first busy cycle, MEM_RDATA = 0x00500093 → IF_ACK two cycles after the request, IF_RDATA = 0x00500093, BE = 1111.
- IF_REQ and DM_REQ (load word at 0x2000) raised in the same cycle → DM granted first; IF is granted in the cycle after DM_ACK; STALL_IF is high throughout.
- Load byte signed at 0x2003, MEM_RDATA = 0x80FF_FF7F → DM_RDATA = 0xFFFFFF80; same access with DM_SIGN = 1 → 0x00000080.
- Store half 0xBEEF at 0x2002 → MEM_BE = 1100, MEM_WDATA = 0xBEEFBEEF, MEM_WE = 1, MEM_ADDR = 0x2000.
- Load word at 0x2001 → no MEM_REQ; DM_ACK and DM_ERR pulse on the next cycle; DM_RDATA = 0.
- With ARB_TIMEOUT_EN defined and MEM_READY held low: DM_ERR pulses after MAX_WAIT = 15 busy cycles. Separately, RST_N asserted mid-access → MEM_REQ drops at once and no ACK appears.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - unified memory port bus between the arbiter (master) and memory (slave)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;

  modport master (
    output req, we, be, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for the unified memory port; optional ARB_TIMEOUT_EN adds a bounded wait
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [31:0]         if_rdata,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [1:0]          dm_size,
  input  logic                dm_sign,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [31:0]         dm_wdata,
  output logic [31:0]         dm_rdata,
  output logic                dm_ack,
  output logic                dm_err,
  mem_port_arbiter_if.master  mem,
  output logic                stall_if,
  output logic                stall_dm
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_BUSY = 2'd1,
    S_DM_BUSY = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [31:0]       NOP_INSN  = 32'h0000_0013;

  state_t            state_q, state_d;

  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              dm_err_q, dm_err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;

  // Load shaping is remembered from grant so the extract does not depend on the requester holding its fields.
  logic [1:0]        ld_off_q, ld_off_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_sign_q, ld_sign_d;

  logic              if_valid, dm_valid;
  logic [1:0]        dm_off;
  logic              dm_misalign;
  logic [3:0]        dm_be;
  logic [31:0]       dm_lanes;
  logic [31:0]       ld_lane;
  logic [31:0]       ld_ext;
  logic              timed_out;

  // A requester acknowledged this cycle is still holding its request; ignore it so it is not re-issued.
  assign if_valid = if_req && !if_ack_q;
  assign dm_valid = dm_req && !dm_ack_q;
  assign dm_off   = dm_addr[1:0];

  assign stall_if = if_req && !if_ack_q;
  assign stall_dm = dm_req && !dm_ack_q;

  // Alignment check, byte enables and store-lane replication for the data requester.
  always_comb begin
    dm_misalign = 1'b0;
    dm_be       = 4'b1111;
    dm_lanes    = dm_wdata;
    case (dm_size)
      2'd0: begin
        dm_be    = 4'b0001 << dm_off;
        dm_lanes = {4{dm_wdata[7:0]}};
      end
      2'd1: begin
        dm_misalign = dm_off[0];
        dm_be       = 4'b0011 << dm_off;
        dm_lanes    = {2{dm_wdata[15:0]}};
      end
      2'd2: begin
        dm_misalign = (dm_off != 2'd0);
      end
      default: begin
        dm_misalign = 1'b1;
      end
    endcase
  end

  // Select the addressed lane of the raw memory word and extend it to 32 bits.
  always_comb begin
    ld_lane = mem.rdata >> {ld_off_q, 3'b000};
    ld_ext  = mem.rdata;
    case (ld_size_q)
      2'd0:    ld_ext = ld_sign_q ? {24'd0, ld_lane[7:0]}
                                  : {{24{ld_lane[7]}}, ld_lane[7:0]};
      2'd1:    ld_ext = ld_sign_q ? {16'd0, ld_lane[15:0]}
                                  : {{16{ld_lane[15]}}, ld_lane[15:0]};
      default: ld_ext = mem.rdata;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_WAIT < 16) ? 4 : $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt_q;

  // Count busy cycles without ready; idle clears it so every grant starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      wait_cnt_q <= '0;
    end else if (!mem.ready) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timed_out = (state_q != S_IDLE) && !mem.ready &&
                     (wait_cnt_q == CNT_W'(MAX_WAIT - 1));
`else
  assign timed_out = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      ld_off_q    <= 2'd0;
      ld_size_q   <= 2'd0;
      ld_sign_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      dm_err_q    <= dm_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      ld_off_q    <= ld_off_d;
      ld_size_q   <= ld_size_d;
      ld_sign_q   <= ld_sign_d;
    end
  end

  // Next state: data wins over fetch because it belongs to the older instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (dm_valid) begin
          if (!dm_misalign) state_d = S_DM_BUSY;
        end else if (if_valid) begin
          state_d = S_IF_BUSY;
        end
      end
      S_IF_BUSY, S_DM_BUSY: begin
        if (mem.ready || timed_out) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs: capture the bus at grant, capture data and ack on completion.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dm_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    ld_off_d    = ld_off_q;
    ld_size_d   = ld_size_q;
    ld_sign_d   = ld_sign_q;
    case (state_q)
      S_IDLE: begin
        if (dm_valid) begin
          if (dm_misalign) begin
            dm_ack_d   = 1'b1;
            dm_err_d   = 1'b1;
            dm_rdata_d = 32'd0;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = dm_we;
            mem_be_d    = dm_be;
            mem_addr_d  = dm_addr & WORD_MASK;
            mem_wdata_d = dm_lanes;
            ld_off_d    = dm_off;
            ld_size_d   = dm_size;
            ld_sign_d   = dm_sign;
          end
        end else if (if_valid) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b1111;
          mem_addr_d  = if_addr & WORD_MASK;
          mem_wdata_d = 32'd0;
        end
      end
      S_IF_BUSY: begin
        if (mem.ready) begin
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = mem.rdata;
        end else if (timed_out) begin
          mem_req_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_rdata_d = NOP_INSN;
        end
      end
      S_DM_BUSY: begin
        if (mem.ready) begin
          mem_req_d  = 1'b0;
          dm_ack_d   = 1'b1;
          dm_rdata_d = ld_ext;
        end else if (timed_out) begin
          mem_req_d  = 1'b0;
          dm_ack_d   = 1'b1;
          dm_err_d   = 1'b1;
          dm_rdata_d = 32'd0;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign mem.req   = mem_req_q;
  assign mem.we    = mem_we_q;
  assign mem.be    = mem_be_q;
  assign mem.addr  = mem_addr_q;
  assign mem.wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign dm_err    = dm_err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule
